// File: rtl/hex_inverter_8b_if.sv
// Operand/result bundle for the bitwise inverter.
// The master drives the operand side; the slave returns the results.
interface hex_inverter_8b_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] MASK;
    logic             EN;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Y_Q;
    logic             Y_VLD;

    modport master (
        output A,
        output MASK,
        output EN,
        input  Y,
        input  Y_Q,
        input  Y_VLD
    );

    modport slave (
        input  A,
        input  MASK,
        input  EN,
        output Y,
        output Y_Q,
        output Y_VLD
    );
endinterface

// File: rtl/hex_inverter_8b.sv
// Masked bitwise inverter: Y = A ^ MASK with zero latency,
// plus a registered copy and a loaded-since-reset flag.
module hex_inverter_8b #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input logic        clk,
    input logic        rst,
    hex_inverter_8b_if.slave bus
);
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             y_vld;

    // Bits are independent; an X on A[i] reaches only Y[i].
    assign y = bus.A ^ bus.MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= RESET_VAL;
            y_vld <= 1'b0;
        end else if (bus.EN) begin
            y_q   <= y;
            y_vld <= 1'b1;
        end
    end

    assign bus.Y     = y;
    assign bus.Y_Q   = y_q;
    assign bus.Y_VLD = y_vld;
endmodule

// File: tb/tb_hex_inverter_8b.sv
// Self-checking bench for hex_inverter_8b: directed cases,
// an exhaustive sweep and randomized traffic against a model.
module tb_hex_inverter_8b;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [7:0] mq;
    logic       mv;

    hex_inverter_8b_if #(.WIDTH(8)) bus ();

    hex_inverter_8b #(
        .WIDTH    (8),
        .RESET_VAL(8'hFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a bit flips exactly where its mask bit is set.
    function automatic logic [7:0] ref_y(input logic [7:0] a,
                                         input logic [7:0] m);
        logic [7:0] r;
        for (int i = 0; i < 8; i++)
            r[i] = m[i] ? (a[i] ? 1'b0 : 1'b1) : a[i];
        return r;
    endfunction

    task automatic tick;
        if (rst) begin
            mq = 8'hFF;
            mv = 1'b0;
        end else if (bus.EN) begin
            mq = ref_y(bus.A, bus.MASK);
            mv = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.EN = 1'b0;
        bus.A = 8'h00;
        bus.MASK = 8'hFF;
        tick();
        tests++;
        if (bus.Y_Q !== 8'hFF) begin
            fails++;
            $display("FAIL reset_yq got %h exp ff", bus.Y_Q);
        end
        tests++;
        if (bus.Y_VLD !== 1'b0) begin
            fails++;
            $display("FAIL reset_vld got %b exp 0", bus.Y_VLD);
        end
    endtask

    task automatic test_comb;
        logic [7:0] av [4];
        logic [7:0] ev [4];
        av = '{8'h01, 8'h00, 8'h55, 8'hFF};
        ev = '{8'hFE, 8'hFF, 8'hAA, 8'h00};
        bus.MASK = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            bus.A = av[i];
            #1;
            tests++;
            if (bus.Y !== ev[i]) begin
                fails++;
                $display("FAIL comb_not a=%h got %h exp %h",
                         av[i], bus.Y, ev[i]);
            end
        end
    endtask

    task automatic test_mask;
        bus.MASK = 8'h0F;
        bus.A = 8'h55;
        #1;
        tests++;
        if (bus.Y !== 8'h5A) begin
            fails++;
            $display("FAIL mask_0f got %h exp 5a", bus.Y);
        end
        bus.MASK = 8'h00;
        bus.A = 8'h3C;
        #1;
        tests++;
        if (bus.Y !== 8'h3C) begin
            fails++;
            $display("FAIL mask_00 got %h exp 3c", bus.Y);
        end
    endtask

    task automatic test_load;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.EN = 1'b1;
        bus.A = 8'h01;
        bus.MASK = 8'hFF;
        tick();
        tests++;
        if (bus.Y_Q !== 8'hFE || bus.Y_VLD !== 1'b1) begin
            fails++;
            $display("FAIL load got %h/%b exp fe/1",
                     bus.Y_Q, bus.Y_VLD);
        end
    endtask

    task automatic test_hold;
        bus.EN = 1'b0;
        bus.A = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (bus.Y_Q !== 8'hFE || bus.Y !== 8'hAA ||
                bus.Y_VLD !== 1'b1) begin
                fails++;
                $display("FAIL hold got q=%h y=%h v=%b exp fe/aa/1",
                         bus.Y_Q, bus.Y, bus.Y_VLD);
            end
        end
        rst = 1'b1;
        bus.EN = 1'b1;
        tick();
        tests++;
        if (bus.Y_Q !== 8'hFF || bus.Y_VLD !== 1'b0) begin
            fails++;
            $display("FAIL rst_over_en got %h/%b exp ff/0",
                     bus.Y_Q, bus.Y_VLD);
        end
        tests++;
        if (bus.Y !== 8'hAA) begin
            fails++;
            $display("FAIL y_in_rst got %h exp aa", bus.Y);
        end
        rst = 1'b0;
    endtask

    task automatic test_exhaustive;
        logic [7:0] a;
        bus.MASK = 8'hFF;
        bus.EN = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            bus.A = a;
            #1;
            tests++;
            if (bus.Y !== ~a) begin
                fails++;
                $display("FAIL exh_y a=%h got %h exp %h",
                         a, bus.Y, ~a);
            end
            tick();
            tests++;
            if (bus.Y_Q !== ~a || bus.Y_VLD !== 1'b1) begin
                fails++;
                $display("FAIL exh_q a=%h got %h/%b exp %h/1",
                         a, bus.Y_Q, bus.Y_VLD, ~a);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 15) == 0);
            bus.EN = 1'($urandom);
            bus.A = 8'($urandom);
            bus.MASK = 8'($urandom);
            #1;
            tests++;
            if (bus.Y !== ref_y(bus.A, bus.MASK)) begin
                fails++;
                $display("FAIL rnd_y a=%h m=%h got %h exp %h",
                         bus.A, bus.MASK, bus.Y,
                         ref_y(bus.A, bus.MASK));
            end
            tick();
            tests++;
            if (bus.Y_Q !== mq || bus.Y_VLD !== mv) begin
                fails++;
                $display("FAIL rnd_q got %h/%b exp %h/%b",
                         bus.Y_Q, bus.Y_VLD, mq, mv);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        mq = 8'hFF;
        mv = 1'b0;
        rst = 1'b1;
        bus.EN = 1'b0;
        bus.A = 8'h00;
        bus.MASK = 8'hFF;
        #1;
        test_reset();
        test_comb();
        test_mask();
        test_load();
        test_hold();
        test_exhaustive();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
